// File: rtl/cbuf_acq_sequencer.sv
// cbuf_acq_sequencer: steps the ADC data mux through header/data/checksum per trigger and
// tracks fill number and DDR3 burst start address.
module cbuf_acq_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  acq_enable,
  input  logic        acq_trig,
  input  logic [13:0] async_num_bursts,
  input  logic        fifo_almost_full,
  output logic        select_fill_hdr,
  output logic        select_waveform_hdr,
  output logic        select_dat,
  output logic        checksum_update,
  output logic        select_checksum,
  output logic        fifo_wr_en,
  output logic [1:0]  fill_type,
  output logic [23:0] fill_num,
  output logic [22:0] burst_start_adr,
  output logic        acq_busy,
  output logic        acq_done,
  output logic        missed_trig,
  output logic        config_err
);
  typedef enum logic [2:0] {IDLE, FHDR, WHDR, DATA, CSUM, DONE} state_t;
  state_t state, state_nxt;
  logic [13:0] n_q, cnt;
  logic        go, armed;
  assign armed = (state == IDLE) && acq_trig && (acq_enable != 2'b00) && !fifo_almost_full;
  assign go    = armed && (async_num_bursts != 14'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? FHDR : IDLE;
      FHDR:    state_nxt = WHDR;
      WHDR:    state_nxt = DATA;
      DATA:    state_nxt = (cnt == n_q - 14'd1) ? CSUM : DATA;
      CSUM:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    select_fill_hdr     = state == FHDR;
    select_waveform_hdr = state == WHDR;
    select_dat          = state == DATA;
    checksum_update     = state == DATA;
    select_checksum     = state == CSUM;
    acq_busy            = state != IDLE;
    acq_done            = state == DONE;
  end
  // fifo_wr_en lags the selects by one cycle to line up with the mux output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n_q             <= '0;
      cnt             <= '0;
      fill_type       <= '0;
      fill_num        <= '0;
      burst_start_adr <= '0;
      fifo_wr_en      <= 1'b0;
      missed_trig     <= 1'b0;
      config_err      <= 1'b0;
    end else begin
      fifo_wr_en  <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;
      missed_trig <= acq_trig && ((state != IDLE) || ((acq_enable != 2'b00) && fifo_almost_full));
      config_err  <= armed && (async_num_bursts == 14'd0);
      if (go) begin
        n_q       <= async_num_bursts;
        fill_type <= acq_enable;
        cnt       <= '0;
      end
      if (state == DATA) cnt <= cnt + 14'd1;
      if (state == DONE) begin
        fill_num        <= fill_num + 24'd1;
        burst_start_adr <= burst_start_adr + 23'(n_q) + 23'd3;
      end
    end
endmodule
